// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: opcode/funct fields, FSM encodings.
// Used by fetch_unit and fetch_next_pc.
package fetch_unit_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_BR   = 4'h8;
  localparam logic [3:0] FN_NOP  = 4'h0;
  localparam logic [3:0] FN_HALT = 4'hF;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R7 = 3'd7;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  // HALT is the NOP opcode (bits 15:12) with the HALT funct (bits 3:0)
  function automatic logic is_halt(input logic [15:0] w);
    return (w[15:12] == OP_NOP) && (w[3:0] == FN_HALT);
  endfunction

  function automatic logic [7:0] br_delta(input logic [5:0] off);
    return {off[5], off, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction RAM bus between the fetch stage and the 128x16 RAM.
// master = fetch (drives address), slave = RAM (returns word).
interface fetch_unit_if;

  logic [7:0]  IMEM_ADDR;
  logic [15:0] IMEM_Q;

  modport master (
    output IMEM_ADDR,
    input  IMEM_Q
  );

  modport slave (
    input  IMEM_ADDR,
    output IMEM_Q
  );

endinterface

// File: rtl/fetch_unit_next_pc.sv
// fetch_next_pc: combinational next-PC mux/adder.
// JUMP inputs exist only when FETCH_JUMP_EN is defined.
module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [7:0] pc_i,
  input  logic       br_taken_i,
  input  logic [5:0] br_offset_i,
`ifdef FETCH_JUMP_EN
  input  logic       jump_i,
  input  logic [7:0] jump_target_i,
`endif
  output logic [7:0] pc_plus2_o,
  output logic [7:0] pc_next_o
);

  logic [7:0] br_tgt;
  logic       sel_jmp;
  logic       sel_br;
  logic       sel_seq;
  logic [7:0] jmp_tgt;

  assign pc_plus2_o = pc_i + 8'd2;
  assign br_tgt     = pc_plus2_o + br_delta(br_offset_i);

`ifdef FETCH_JUMP_EN
  assign sel_jmp = jump_i;
  assign jmp_tgt = {jump_target_i[7:1], 1'b0};
`else
  assign sel_jmp = 1'b0;
  assign jmp_tgt = 8'h00;
`endif

  // one-hot selects encode jump > branch > sequential
  assign sel_br  = br_taken_i & ~sel_jmp;
  assign sel_seq = ~br_taken_i & ~sel_jmp;

  always_comb begin
    pc_next_o = pc_plus2_o;
    unique case (1'b1)
      sel_jmp: pc_next_o = jmp_tgt;
      sel_br:  pc_next_o = br_tgt;
      sel_seq: pc_next_o = pc_plus2_o;
      default: pc_next_o = pc_plus2_o;
    endcase
    pc_next_o[0] = 1'b0;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, RUN/HALT FSM and retired-instruction counter.
// Define FETCH_JUMP_EN to add the JUMP/JUMP_TARGET redirect ports.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             STALL,
  input  logic             BR_TAKEN,
  input  logic [5:0]       BR_OFFSET,
`ifdef FETCH_JUMP_EN
  input  logic             JUMP,
  input  logic [7:0]       JUMP_TARGET,
`endif
  fetch_unit_if.master     imem,
  output logic [15:0]      INSTR,
  output logic [7:0]       PC_OUT,
  output logic [7:0]       PC_PLUS2,
  output logic             INSTR_VALID,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_COUNT
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pc_next;

  fetch_next_pc u_next_pc (
    .pc_i          (pc_q),
    .br_taken_i    (BR_TAKEN),
    .br_offset_i   (BR_OFFSET),
`ifdef FETCH_JUMP_EN
    .jump_i        (JUMP),
    .jump_target_i (JUMP_TARGET),
`endif
    .pc_plus2_o    (PC_PLUS2),
    .pc_next_o     (pc_next)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH_RUN;
      pc_q    <= {PC_RESET[7:1], 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    INSTR_VALID = 1'b0;
    INSTR       = 16'h0000;
    HALTED      = 1'b0;
    unique case (state_q)
      FETCH_RUN: begin
        INSTR_VALID = ~RESET;
        INSTR       = RESET ? 16'h0000 : imem.IMEM_Q;
        if (!STALL) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
          // a HALT word retires but does not advance the PC
          if (is_halt(imem.IMEM_Q)) begin
            state_d = FETCH_HALT;
          end else begin
            pc_d = pc_next;
          end
        end
      end
      FETCH_HALT: begin
        HALTED = ~RESET;
      end
      default: begin
        state_d = FETCH_RUN;
      end
    endcase
  end

  assign imem.IMEM_ADDR = pc_q;
  assign PC_OUT         = pc_q;
  assign INSTR_COUNT    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [5:0]  BR_OFFSET = 6'd0;
  logic        JUMP = 1'b0;
  logic [7:0]  JUMP_TARGET = 8'h00;
  logic [15:0] INSTR;
  logic [7:0]  PC_OUT, PC_PLUS2;
  logic        INSTR_VALID, HALTED;
  logic [15:0] INSTR_COUNT;

  logic [15:0] s_instr;
  logic [7:0]  s_pc, s_pc2;
  logic        s_valid, s_halted;
  logic [3:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [15:0] W   = 16'h1234;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] HLT = 16'h000F;

  typedef struct {
    string       nm;
    bit          sat;
    logic [7:0]  pc;
    logic        v;
    logic        h;
    logic [15:0] cnt;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit_if imem_if ();
  fetch_unit_if sat_if ();

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_RESET(8'h00), .CNT_W(16)) u_dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .STALL       (STALL),
    .BR_TAKEN    (BR_TAKEN),
    .BR_OFFSET   (BR_OFFSET),
`ifdef FETCH_JUMP_EN
    .JUMP        (JUMP),
    .JUMP_TARGET (JUMP_TARGET),
`endif
    .imem        (imem_if.master),
    .INSTR       (INSTR),
    .PC_OUT      (PC_OUT),
    .PC_PLUS2    (PC_PLUS2),
    .INSTR_VALID (INSTR_VALID),
    .HALTED      (HALTED),
    .INSTR_COUNT (INSTR_COUNT)
  );

  fetch_unit #(.PC_RESET(8'h00), .CNT_W(4)) u_sat (
    .CLK         (CLK),
    .RESET       (RESET),
    .STALL       (1'b0),
    .BR_TAKEN    (1'b0),
    .BR_OFFSET   (6'd0),
`ifdef FETCH_JUMP_EN
    .JUMP        (1'b0),
    .JUMP_TARGET (8'h00),
`endif
    .imem        (sat_if.master),
    .INSTR       (s_instr),
    .PC_OUT      (s_pc),
    .PC_PLUS2    (s_pc2),
    .INSTR_VALID (s_valid),
    .HALTED      (s_halted),
    .INSTR_COUNT (s_cnt)
  );

  assign sat_if.IMEM_Q = 16'h1111;

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (e.sat) begin
        if (s_cnt != e.cnt[3:0]) begin
          failures++;
          $display("FAIL %s: count=%h expected=%h", e.nm, s_cnt, e.cnt[3:0]);
        end
      end else if (PC_OUT !== e.pc || imem_if.IMEM_ADDR !== e.pc
                   || PC_PLUS2 !== 8'(e.pc + 8'd2)
                   || INSTR_VALID !== e.v || HALTED !== e.h
                   || INSTR_COUNT !== e.cnt || INSTR !== e.instr) begin
        failures++;
        $display("FAIL %s: pc=%h addr=%h pc2=%h v=%b h=%b cnt=%h instr=%h expected pc=%h v=%b h=%b cnt=%h instr=%h",
                 e.nm, PC_OUT, imem_if.IMEM_ADDR, PC_PLUS2, INSTR_VALID,
                 HALTED, INSTR_COUNT, INSTR, e.pc, e.v, e.h, e.cnt, e.instr);
      end
    end
  end

  task automatic s(input logic rst, input logic stl, input logic br,
                   input logic [5:0] off, input logic [15:0] q,
                   input bit chk, input logic [7:0] epc, input logic ev,
                   input logic eh, input logic [15:0] ecnt, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET          = rst;
    STALL          = stl;
    BR_TAKEN       = br;
    BR_OFFSET      = off;
    imem_if.IMEM_Q = q;
    if (chk) begin
      e.nm    = nm;
      e.sat   = 1'b0;
      e.pc    = epc;
      e.v     = ev;
      e.h     = eh;
      e.cnt   = ecnt;
      e.instr = ev ? q : 16'h0000;
      exp_q.push_back(e);
    end
  endtask

  task automatic sat_expect(input logic [3:0] c, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    e.nm    = nm;
    e.sat   = 1'b1;
    e.pc    = 8'h00;
    e.v     = 1'b0;
    e.h     = 1'b0;
    e.cnt   = {12'h000, c};
    e.instr = 16'h0000;
    exp_q.push_back(e);
  endtask

  initial begin
    imem_if.IMEM_Q = W;
    repeat (2) @(posedge CLK);
    s(1, 0, 0, 6'd0, W,       1, 8'h00, 0, 0, 16'd0,  "reset");
    s(0, 0, 0, 6'd0, W,       1, 8'h00, 1, 0, 16'd0,  "seq0");
    s(0, 0, 0, 6'd0, NOP,     1, 8'h02, 1, 0, 16'd1,  "seq1");
    s(0, 0, 0, 6'd0, 16'h100F,1, 8'h04, 1, 0, 16'd2,  "seq2");
    s(0, 0, 0, 6'd0, 16'hF00F,1, 8'h06, 1, 0, 16'd3,  "seq3");
    s(0, 1, 1, 6'd2, HLT,     1, 8'h08, 1, 0, 16'd4,  "stall0");
    s(0, 1, 0, 6'd0, W,       1, 8'h08, 1, 0, 16'd4,  "stall1");
    s(0, 1, 0, 6'd0, W,       1, 8'h08, 1, 0, 16'd4,  "stall2");
    s(0, 0, 0, 6'd0, W,       1, 8'h08, 1, 0, 16'd4,  "stall_rel");
    s(0, 0, 0, 6'd0, W,       1, 8'h0A, 1, 0, 16'd5,  "seq_0a");
    s(0, 0, 0, 6'd0, W,       1, 8'h0C, 1, 0, 16'd6,  "seq_0c");
    s(0, 0, 1, 6'b000010, W,  1, 8'h0E, 1, 0, 16'd7,  "br_fwd");
    s(0, 0, 1, 6'b111101, W,  1, 8'h14, 1, 0, 16'd8,  "br_m3");
    s(0, 0, 1, 6'b111110, W,  1, 8'h10, 1, 0, 16'd9,  "br_m2");
    s(0, 0, 0, 6'd0, W,       1, 8'h0E, 1, 0, 16'd10, "br_back");
    s(0, 0, 0, 6'd0, W,       1, 8'h10, 1, 0, 16'd11, "seq_10");
    s(0, 0, 0, 6'd0, W,       1, 8'h12, 1, 0, 16'd12, "seq_12");
    s(0, 0, 0, 6'd0, W,       1, 8'h14, 1, 0, 16'd13, "seq_14");
    s(0, 0, 1, 6'b000100, HLT,1, 8'h16, 1, 0, 16'd14, "halt_fetch");
    s(0, 0, 1, 6'd2, W,       1, 8'h16, 0, 1, 16'd15, "halted0");
    s(0, 1, 1, 6'd2, W,       1, 8'h16, 0, 1, 16'd15, "halted1");
    s(0, 0, 0, 6'd0, HLT,     1, 8'h16, 0, 1, 16'd15, "halted2");
    s(1, 0, 0, 6'd0, W,       0, 8'h00, 0, 0, 16'd0,  "");
    s(0, 0, 1, 6'b111110, W,  1, 8'h00, 1, 0, 16'd0,  "after_rst");
    s(0, 0, 0, 6'd0, W,       1, 8'hFE, 1, 0, 16'd1,  "pc_fe");
    s(0, 0, 0, 6'd0, W,       1, 8'h00, 1, 0, 16'd2,  "wrap");
    s(0, 1, 0, 6'd0, HLT,     1, 8'h02, 1, 0, 16'd3,  "stall_halt");
    s(0, 0, 0, 6'd0, HLT,     1, 8'h02, 1, 0, 16'd3,  "halt_b");
    s(0, 0, 0, 6'd0, W,       1, 8'h02, 0, 1, 16'd4,  "halted_b");
`ifdef FETCH_JUMP_EN
    s(1, 0, 0, 6'd0, W,       0, 8'h00, 0, 0, 16'd0,  "");
    JUMP        = 1'b1;
    JUMP_TARGET = 8'h23;
    s(0, 0, 1, 6'b000010, W,  1, 8'h00, 1, 0, 16'd0,  "jump");
    s(0, 0, 0, 6'd0, W,       0, 8'h00, 0, 0, 16'd0,  "");
    JUMP        = 1'b0;
    exp_q.push_back('{nm: "jump_tgt", sat: 1'b0, pc: 8'h22, v: 1'b1,
                      h: 1'b0, cnt: 16'd1, instr: W});
`endif
    s(1, 0, 0, 6'd0, W,       0, 8'h00, 0, 0, 16'd0,  "");
    s(0, 0, 0, 6'd0, W,       0, 8'h00, 0, 0, 16'd0,  "");
    sat_expect(4'd1, "sat_cnt1");
    for (int i = 0; i < 20; i++)
      s(0, 0, 0, 6'd0, W,     0, 8'h00, 0, 0, 16'd0,  "");
    sat_expect(4'hF, "sat_full");
    sat_expect(4'hF, "sat_hold");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      failures++;
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
